// File: rtl/mem_acesso_ctrl.sv
// Load/store initiator for a 128-word data memory: sub-word load extract, byte/halfword store via RMW.
// Latency: load 3 edges, word store 2, sub-word store 4, misaligned 1; req ignored while busy (no queueing).
module mem_acesso_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERR} state_t;

  state_t            state, state_nxt;
  logic              st_q, sx_q;
  logic [1:0]        size_q, boff_q;
  logic              align_err;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_val, merged;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  assign align_err = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);

  always_comb begin
    byte_lane = mem_rdata[7:0];
    case (boff_q)
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      2'd3:    byte_lane = mem_rdata[31:24];
      default: byte_lane = mem_rdata[7:0];
    endcase
    half_lane = boff_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      2'b00:   load_val = {{(DATA_W-8){sx_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{(DATA_W-16){sx_q & half_lane[15]}}, half_lane};
      default: load_val = mem_rdata;
    endcase

    // mem_wdata still holds the latched store data while in CAP
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (boff_q)
        2'd1:    merged[15:8]  = mem_wdata[7:0];
        2'd2:    merged[23:16] = mem_wdata[7:0];
        2'd3:    merged[31:24] = mem_wdata[7:0];
        default: merged[7:0]   = mem_wdata[7:0];
      endcase
    end else if (boff_q[1]) begin
      merged[31:16] = mem_wdata[15:0];
    end else begin
      merged[15:0] = mem_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (align_err)                         state_nxt = ERR;
          else if (is_store && size == 2'b10)    state_nxt = WR;
          else                                   state_nxt = RD;
        end
      end
      RD: begin
        mem_re    = 1'b1;
        state_nxt = CAP;
      end
      CAP:     state_nxt = st_q ? WR : IDLE;
      WR: begin
        mem_we    = 1'b1;
        state_nxt = IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= 1'b0;
      sx_q       <= 1'b0;
      size_q     <= 2'b00;
      boff_q     <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            st_q      <= is_store;
            sx_q      <= sign_ext;
            size_q    <= size;
            boff_q    <= addr[1:0];
            mem_addr  <= addr[ADDR_W+1:2];
            mem_wdata <= wdata;
            // rejected requests complete in the very next cycle
            if (align_err) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
            end
          end
        end
        CAP: begin
          if (st_q) begin
            mem_wdata <= merged;
          end else begin
            rdata <= load_val;
            done  <= 1'b1;
          end
        end
        WR:      done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_acesso_ctrl.sv
// Directed bench for mem_acesso_ctrl with a behavioural 128-word memory.
module tb_mem_acesso_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, is_store, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misaligned, mem_we, mem_re;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [6:0]  mem_addr;

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;

  int         cyc;
  logic [7:0] re_m, we_m;
  logic [6:0] ad;
  int         n_re, n_we, n_done;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  mem_acesso_ctrl #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misaligned(misaligned), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  // cyc = negedges after acceptance until done; bit i of masks = access in cycle i+1
  task automatic run_op(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    issue(st, sz, sx, a, wd);
    cyc = 10; re_m = '0; we_m = '0; ad = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_re) begin re_m[i] = 1'b1; ad = mem_addr; end
      if (mem_we) begin we_m[i] = 1'b1; ad = mem_addr; end
      if (done) begin cyc = i + 1; break; end
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] exp);
    run_op(1'b0, sz, sx, a, 32'h0);
    chk({tag, "_lat"}, 32'(cyc), 32'd3);
    chk({tag, "_mis"}, 32'(misaligned), 32'd0);
    chk(tag, rdata, exp);
  endtask

  task automatic err_chk(input string tag, input logic st, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] prev_rdata);
    run_op(st, sz, 1'b0, a, 32'hFFFF_FFFF);
    chk({tag, "_lat"}, 32'(cyc), 32'd1);
    chk({tag, "_mis"}, 32'(misaligned), 32'd1);
    chk({tag, "_acc"}, {16'h0, re_m, we_m}, 32'h0);
    chk({tag, "_rdata"}, rdata, prev_rdata);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // async reset mid-cycle while a word store is in WR
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h1234_5678);
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {26'h0, busy, done, misaligned, mem_we, mem_re, 1'b0}, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // word store then load
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("sw_lat", 32'(cyc), 32'd2);
    chk("sw_acc", {16'h0, re_m, we_m}, 32'h0001);
    chk("sw_addr", 32'(ad), 32'd4);
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_lat", 32'(cyc), 32'd3);
    chk("lw_acc", {16'h0, re_m, we_m}, 32'h0100);
    chk("lw_addr", 32'(ad), 32'd4);
    chk("lw_data", rdata, 32'hDEAD_BEEF);

    // byte store RMW
    run_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    run_op(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAB);
    chk("sb_lat", 32'(cyc), 32'd4);
    chk("sb_acc", {16'h0, re_m, we_m}, 32'h0104);
    chk("sb_addr", 32'(ad), 32'd8);
    chk("sb_rdata_kept", rdata, 32'hDEAD_BEEF);
    load_chk("sb_lw", 2'b10, 1'b0, 32'h20, 32'h11AB_3344);
    run_op(1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA_5566);
    chk("sh_lat", 32'(cyc), 32'd4);
    load_chk("sh_lw", 2'b10, 1'b0, 32'h20, 32'h5566_3344);

    // sub-word loads
    run_op(1'b1, 2'b10, 1'b0, 32'h30, 32'h80F0_017F);
    load_chk("lb30", 2'b00, 1'b1, 32'h30, 32'h0000_007F);
    load_chk("lb32", 2'b00, 1'b1, 32'h32, 32'hFFFF_FFF0);
    load_chk("lbu32", 2'b00, 1'b0, 32'h32, 32'h0000_00F0);
    load_chk("lb33", 2'b00, 1'b1, 32'h33, 32'hFFFF_FF80);
    load_chk("lh32", 2'b01, 1'b1, 32'h32, 32'hFFFF_80F0);
    load_chk("lhu30", 2'b01, 1'b0, 32'h30, 32'h0000_017F);

    // misaligned requests
    err_chk("mis_lw31", 1'b0, 2'b10, 32'h31, 32'h0000_017F);
    err_chk("mis_sh33", 1'b1, 2'b01, 32'h33, 32'h0000_017F);
    err_chk("mis_sz11", 1'b0, 2'b11, 32'h30, 32'h0000_017F);
    load_chk("mis_word_kept", 2'b10, 1'b0, 32'h30, 32'h80F0_017F);

    // req held high through a whole load: exactly one operation
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
    n_re = 0; n_done = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_re += int'(mem_re);
      n_done += int'(done);
      if (i == 2) req = 1'b0;
    end
    chk("held_re", 32'(n_re), 32'd1);
    chk("held_done", 32'(n_done), 32'd1);
    chk("held_data", rdata, 32'hDEAD_BEEF);

    // back-to-back word stores: new req accepted at the edge where done is high
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'hCAFE_F00D;
    n_we = 0; n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_we += int'(mem_we);
      n_done += int'(done);
      if (i == 2) req = 1'b0;
    end
    chk("b2b_we", 32'(n_we), 32'd2);
    chk("b2b_done", 32'(n_done), 32'd2);

    // address wrap
    run_op(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A5_A5A5);
    chk("wrap_3fc", 32'(ad), 32'd127);
    run_op(1'b1, 2'b10, 1'b0, 32'h200, 32'h0BAD_C0DE);
    chk("wrap_200", 32'(ad), 32'd0);
    load_chk("wrap_lw0", 2'b10, 1'b0, 32'h0, 32'h0BAD_C0DE);
    load_chk("wrap_lw7fc", 2'b10, 1'b0, 32'h7FC, 32'hA5A5_A5A5);

    // reset pulsed during WR of a byte store: no write happens
    issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_0077);
    repeat (3) @(negedge clk);
    chk("sbrst_in_wr", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sbrst_we", 32'(mem_we), 32'd0);
    chk("sbrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_we += int'(mem_we);
    end
    chk("sbrst_no_we", 32'(n_we), 32'd0);
    load_chk("sbrst_word", 2'b10, 1'b0, 32'h20, 32'h5566_3344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
